// File: rtl/sev_seg_scan_driver.sv
// Seven-segment back end: hex / double-dabble decimal conversion of a 16-bit value
// and time-multiplexed scanning of four active-low Basys3 digits.
module sev_seg_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          BLANK_LEAD  = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] DATA_IN,
    input  logic        MODE,
    output logic [7:0]  CATHODES,
    output logic [3:0]  ANODES,
    output logic        BUSY,
    output logic        OVF
);

    localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    state_t           state_q, state_d;
    logic             valid_q, valid_d;
    logic [15:0]      cap_data_q, cap_data_d;
    logic             cap_mode_q, cap_mode_d;
    logic [19:0]      bcd_q, bcd_d;
    logic [15:0]      shreg_q, shreg_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0][7:0]  disp_q, disp_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic [REF_W-1:0] ref_q, ref_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [7:0]       cath_q, cath_d;

    logic [19:0]      adj;
    logic [35:0]      shifted;
    logic             blank3, blank2, blank1;

    function automatic logic [7:0] seg_hex(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        cap_data_d = cap_data_q;
        cap_mode_d = cap_mode_q;
        bcd_d      = bcd_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        disp_d     = disp_q;
        busy_d     = busy_q;
        ovf_d      = ovf_q;

        // Double-dabble step: add 3 to every nibble >= 5, then shift the pair left.
        adj = bcd_q;
        for (int unsigned i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj, shreg_q} << 1;

        blank3 = BLANK_LEAD && (bcd_q[15:12] == 4'd0);
        blank2 = blank3 && (bcd_q[11:8] == 4'd0);
        blank1 = blank2 && (bcd_q[7:4] == 4'd0);

        case (state_q)
            ST_IDLE: begin
                if (!valid_q || (DATA_IN != cap_data_q) || (MODE != cap_mode_q)) begin
                    cap_data_d = DATA_IN;
                    cap_mode_d = MODE;
                    valid_d    = 1'b1;
                    bcd_d      = '0;
                    shreg_d    = DATA_IN;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = MODE ? ST_SHIFT : ST_COMMIT;
                end
            end
            ST_SHIFT: begin
                bcd_d   = shifted[35:16];
                shreg_d = shifted[15:0];
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (!cap_mode_q) begin
                    ovf_d = 1'b0;
                    for (int unsigned i = 0; i < 4; i++) begin
                        disp_d[i] = seg_hex(cap_data_q[4*i +: 4]);
                    end
                end else if (bcd_q[19:16] != 4'd0) begin
                    ovf_d  = 1'b1;
                    disp_d = {4{SEG_DASH}};
                end else begin
                    ovf_d     = 1'b0;
                    disp_d[3] = blank3 ? SEG_BLANK : seg_hex(bcd_q[15:12]);
                    disp_d[2] = blank2 ? SEG_BLANK : seg_hex(bcd_q[11:8]);
                    disp_d[1] = blank1 ? SEG_BLANK : seg_hex(bcd_q[7:4]);
                    disp_d[0] = seg_hex(bcd_q[3:0]);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Outputs are registered from next-state values so they always match idx_q/disp_q.
    always_comb begin
        ref_d = ref_q + REF_W'(1);
        idx_d = idx_q;
        if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            idx_d = idx_q + 2'd1;
        end
        an_d   = ~(4'b0001 << idx_d);
        cath_d = disp_d[idx_d];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            cap_data_q <= '0;
            cap_mode_q <= 1'b0;
            bcd_q      <= '0;
            shreg_q    <= '0;
            cnt_q      <= '0;
            disp_q     <= '1;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ref_q      <= '0;
            idx_q      <= '0;
            an_q       <= 4'b1110;
            cath_q     <= 8'hFF;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            cap_data_q <= cap_data_d;
            cap_mode_q <= cap_mode_d;
            bcd_q      <= bcd_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            disp_q     <= disp_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
            ref_q      <= ref_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            cath_q     <= cath_d;
        end
    end

    assign CATHODES = cath_q;
    assign ANODES   = an_q;
    assign BUSY     = busy_q;
    assign OVF      = ovf_q;

endmodule

// File: tb/tb_sev_seg_scan_driver.sv
// Bench for sev_seg_scan_driver: two instances (leading-zero blanking on/off) checked
// every cycle against an arithmetic display model, plus directed literal checks.
module tb_sev_seg_scan_driver;

    localparam int DIV = 4;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic        mode;
    logic [7:0]  b_cath, n_cath;
    logic [3:0]  b_an, n_an;
    logic        b_busy, n_busy, b_ovf, n_ovf;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    sev_seg_scan_driver #(.REFRESH_DIV(DIV), .BLANK_LEAD(1'b1)) dut_b (
        .CLK(clk), .RESET(rst), .DATA_IN(din), .MODE(mode),
        .CATHODES(b_cath), .ANODES(b_an), .BUSY(b_busy), .OVF(b_ovf)
    );

    sev_seg_scan_driver #(.REFRESH_DIV(DIV), .BLANK_LEAD(1'b0)) dut_n (
        .CLK(clk), .RESET(rst), .DATA_IN(din), .MODE(mode),
        .CATHODES(n_cath), .ANODES(n_an), .BUSY(n_busy), .OVF(n_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: what value is shown and how, plus a busy countdown.
    bit          m_valid;
    int          m_cap;
    bit          m_capmode;
    int          m_left;
    int          m_val;
    int          m_kind;   // 0 blank, 1 hex, 2 decimal
    bit          m_ovf;
    int          m_n;      // cycles since reset, drives the scan position

    function automatic logic [7:0] seg_of(input int n);
        case (n)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90; 10: return 8'h88; 11: return 8'h83;
            12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    function automatic int pow10(input int i);
        int p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        return p;
    endfunction

    function automatic logic [7:0] exp_seg(input bit bl, input int i);
        if (m_kind == 0) return 8'hFF;
        if (m_kind == 1) return seg_of((m_val >> (4 * i)) & 15);
        if (m_val > 9999) return 8'hBF;
        if (bl && i > 0 && m_val < pow10(i)) return 8'hFF;
        return seg_of((m_val / pow10(i)) % 10);
    endfunction

    task automatic model_step();
        if (rst) begin
            m_valid = 0; m_left = 0; m_kind = 0; m_ovf = 0; m_n = 0;
        end else begin
            m_n++;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_val  = m_cap;
                    m_kind = m_capmode ? 2 : 1;
                    m_ovf  = m_capmode && (m_cap > 9999);
                end
            end else if (!m_valid || int'(din) != m_cap || mode != m_capmode) begin
                m_valid   = 1;
                m_cap     = int'(din);
                m_capmode = mode;
                m_left    = mode ? 17 : 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s t=%0t wait bound expired", name, $time);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        int idx;
        logic [3:0] e_an;
        @(posedge clk);
        #2;
        if (chk_en) begin
            idx  = (m_n / DIV) % 4;
            e_an = ~(4'b0001 << idx);
            chk("b_anodes", b_an, e_an);
            chk("n_anodes", n_an, e_an);
            chk("b_cathodes", b_cath, exp_seg(1'b1, idx));
            chk("n_cathodes", n_cath, exp_seg(1'b0, idx));
            chk("b_busy", b_busy, m_left > 0);
            chk("n_busy", n_busy, m_left > 0);
            chk("b_ovf", b_ovf, m_ovf);
            chk("n_ovf", n_ovf, m_ovf);
        end
    end

    // Counts BUSY cycles of one conversion started by inputs set just before.
    task automatic measure_busy(output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #2;
            if (b_busy) n++;
            else if (n > 0) break;
        end
    endtask

    task automatic dig(input string nm, input int d, input logic [7:0] eb, input logic [7:0] en);
        bit found = 0;
        for (int k = 0; k < 64 && !found; k++) begin
            @(posedge clk);
            #2;
            if (b_an === ~(4'b0001 << d)) found = 1;
        end
        if (!found) timeout_fail(nm);
        else begin
            chk({nm, "_b"}, b_cath, eb);
            chk({nm, "_n"}, n_cath, en);
        end
    endtask

    task automatic set_in(input logic [15:0] v, input logic m);
        @(negedge clk);
        din  = v;
        mode = m;
    endtask

    initial begin
        int nb;
        bit bz [60];
        int ones;

        rst = 1'b1; din = 16'h1234; mode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        chk("reset_anodes", b_an, 4'b1110);
        chk("reset_cathodes", b_cath, 8'hFF);
        chk("reset_busy", b_busy, 1'b0);
        chk("reset_ovf", b_ovf, 1'b0);

        // 1: hex 1234
        rst = 1'b0;
        measure_busy(nb);
        chk("hex_busy_len", nb, 1);
        dig("hex_d0", 0, 8'h99, 8'h99);
        dig("hex_d1", 1, 8'hB0, 8'hB0);
        dig("hex_d2", 2, 8'hA4, 8'hA4);
        dig("hex_d3", 3, 8'hF9, 8'hF9);

        // 2: decimal 1234
        set_in(16'd1234, 1'b1);
        measure_busy(nb);
        chk("dec_busy_len", nb, 17);
        dig("dec_d0", 0, 8'hB0 ^ 8'h29, 8'h99);
        dig("dec_d1", 1, 8'hB0, 8'hB0);
        dig("dec_d2", 2, 8'hA4, 8'hA4);
        dig("dec_d3", 3, 8'hF9, 8'hF9);
        chk("dec_ovf", b_ovf, 1'b0);

        // 3: decimal 7, blanking vs no blanking
        set_in(16'd7, 1'b1);
        measure_busy(nb);
        chk("seven_busy_len", nb, 17);
        dig("seven_d0", 0, 8'hF8, 8'hF8);
        dig("seven_d1", 1, 8'hFF, 8'hC0);
        dig("seven_d2", 2, 8'hFF, 8'hC0);
        dig("seven_d3", 3, 8'hFF, 8'hC0);

        // 4: overflow then zero
        set_in(16'd65535, 1'b1);
        measure_busy(nb);
        for (int d = 0; d < 4; d++) dig("ovf_dash", d, 8'hBF, 8'hBF);
        chk("ovf_flag", b_ovf, 1'b1);
        set_in(16'd0, 1'b1);
        measure_busy(nb);
        dig("zero_d0", 0, 8'hC0, 8'hC0);
        dig("zero_d1", 1, 8'hFF, 8'hC0);
        dig("zero_d3", 3, 8'hFF, 8'hC0);
        chk("zero_ovf", b_ovf, 1'b0);

        // 5: input change mid-conversion
        set_in(16'd100, 1'b1);
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #2;
            bz[k] = b_busy;
            if (k == 4) begin
                @(negedge clk);
                din = 16'd200;
            end
        end
        ones = 0;
        for (int k = 0; k < 60; k++) ones += int'(bz[k]);
        chk("chg_busy_total", ones, 34);
        chk("chg_first_end", bz[16] && !bz[17], 1'b1);
        chk("chg_second_end", bz[34] && !bz[35], 1'b1);
        dig("chg_d0", 0, 8'hC0, 8'hC0);
        dig("chg_d1", 1, 8'hC0, 8'hC0);
        dig("chg_d2", 2, 8'hA4, 8'hA4);
        dig("chg_d3", 3, 8'hFF, 8'hC0);

        // 6: reset during shift
        set_in(16'd4321, 1'b1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("abort_cathodes", b_cath, 8'hFF);
        chk("abort_anodes", b_an, 4'b1110);
        chk("abort_busy", b_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        measure_busy(nb);
        chk("abort_rerun_len", nb, 17);
        dig("abort_d0", 0, 8'hF9, 8'hF9);
        dig("abort_d3", 3, 8'h99, 8'h99);

        // Random traffic
        for (int it = 0; it < 400; it++) begin
            @(negedge clk);
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                rst = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0: din = 16'($urandom_range(0, 99));
                    1: din = 16'($urandom_range(0, 9999));
                    2: din = 16'($urandom);
                    default: din = 16'($urandom_range(9990, 10010));
                endcase
                mode = 1'($urandom);
            end
            repeat ($urandom_range(1, 25)) @(negedge clk);
        end
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #3;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
